// File: rtl/multicycle_control.sv
// Control FSM for the multi-cycle LEGv8 core. It sequences FETCH/DECODE/execute
// states over a shared memory with a req/ready handshake. It also counts retired
// instructions and pulses on illegal opcodes and on memory timeouts.
module multicycle_control #(
  parameter int OPCODE_W    = 11,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                alu_zero,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                reg2loc,
  output logic                alu_src,
  output logic [1:0]          alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [2:0]          state,
  output logic [CNT_W-1:0]    instr_count,
  output logic                illegal,
  output logic                mem_error
);

  localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC_R = 3'd2,
    ADDR   = 3'd3,
    MEM_RD = 3'd4,
    MEM_WR = 3'd5,
    WB     = 3'd6,
    BRANCH = 3'd7
  } stateT;

  stateT             curState, nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic              ldFlag, isBFlag;
  logic [CNT_W-1:0]  instrCount;
  logic              illegalQ, memErrQ;

  // Raw (pre-reset-gating) control outputs from the decode block.
  logic       memReq, iOrD, memRead, memWrite, irWrite, pcWrite, pcSrc;
  logic       reg2locC, aluSrc, memToReg, regWrite;
  logic [1:0] aluOp;
  logic       retire, illegalSet;

  // Opcode classes; only the top 11 bits carry the LEGv8 opcode.
  logic [10:0] opc;
  logic        isRType, isLdur, isStur, isCbz, isBOp;
  assign opc     = opcode[OPCODE_W-1 -: 11];
  assign isRType = (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_AND) || (opc == OP_ORR);
  assign isLdur  = (opc == OP_LDUR);
  assign isStur  = (opc == OP_STUR);
  assign isCbz   = (opc[10:3] == 8'b10110100);
  assign isBOp   = (opc[10:5] == 6'b000101);

  // Memory states request every cycle. A wait cycle is a request without
  // ready, and the last permitted wait cycle aborts (ready in it still wins).
  logic memState, memWait, timeout;
  assign memState = (curState == FETCH) || (curState == MEM_RD) || (curState == MEM_WR);
  assign memWait  = memState && !mem_ready;
  assign timeout  = memWait && (waitCnt == WAIT_W'(MEM_TIMEOUT - 1));

  // State register, wait counter, decode flags, retire counter and event pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      curState   <= FETCH;
      waitCnt    <= '0;
      ldFlag     <= 1'b0;
      isBFlag    <= 1'b0;
      instrCount <= '0;
      illegalQ   <= 1'b0;
      memErrQ    <= 1'b0;
    end else begin
      curState <= nextState;
      // Leaving a memory state (ready or abort) always clears, so every entry starts at 0.
      waitCnt  <= (memWait && !timeout) ? waitCnt + WAIT_W'(1) : '0;
      illegalQ <= illegalSet;
      memErrQ  <= timeout;
      if (retire) instrCount <= instrCount + CNT_W'(1);
      // Rewritten on every decode so an older LDUR never leaks into a later WB.
      if (curState == DECODE) begin
        ldFlag  <= isLdur;
        isBFlag <= isBOp;
      end
    end
  end

  // Next-state and Moore outputs; ir_write/pc_write also qualified by ready/zero.
  always_comb begin
    nextState  = curState;
    memReq     = 1'b0;
    iOrD       = 1'b0;
    memRead    = 1'b0;
    memWrite   = 1'b0;
    irWrite    = 1'b0;
    pcWrite    = 1'b0;
    pcSrc      = 1'b0;
    reg2locC   = 1'b0;
    aluSrc     = 1'b0;
    aluOp      = 2'b00;
    memToReg   = 1'b0;
    regWrite   = 1'b0;
    retire     = 1'b0;
    illegalSet = 1'b0;
    case (curState)
      FETCH: begin
        memReq  = 1'b1;
        memRead = 1'b1;
        if (mem_ready) begin
          irWrite   = 1'b1;
          pcWrite   = 1'b1;
          nextState = DECODE;
        end else if (timeout) begin
          nextState = FETCH;  // refetch the same PC
        end
      end
      DECODE: begin
        if (isRType)              nextState = EXEC_R;
        else if (isLdur || isStur) nextState = ADDR;
        else if (isCbz || isBOp)   nextState = BRANCH;
        else begin
          illegalSet = 1'b1;
          nextState  = FETCH;
        end
      end
      EXEC_R: begin
        aluOp     = 2'b10;
        nextState = WB;
      end
      ADDR: begin
        aluSrc    = 1'b1;
        reg2locC  = 1'b1;
        nextState = ldFlag ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        memReq  = 1'b1;
        memRead = 1'b1;
        iOrD    = 1'b1;
        if (mem_ready)    nextState = WB;
        else if (timeout) nextState = FETCH;
      end
      MEM_WR: begin
        memReq   = 1'b1;
        memWrite = 1'b1;
        iOrD     = 1'b1;
        reg2locC = 1'b1;
        if (mem_ready) begin
          nextState = FETCH;
          retire    = 1'b1;
        end else if (timeout) begin
          nextState = FETCH;
        end
      end
      WB: begin
        regWrite  = 1'b1;
        memToReg  = ldFlag;
        nextState = FETCH;
        retire    = 1'b1;
      end
      BRANCH: begin
        reg2locC  = 1'b1;
        aluOp     = 2'b01;
        pcSrc     = 1'b1;
        pcWrite   = isBFlag | alu_zero;
        nextState = FETCH;
        retire    = 1'b1;
      end
      default: nextState = FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, so combinational
  // outputs are gated with reset to keep mem_req low while it is asserted.
  assign mem_req     = reset & memReq;
  assign i_or_d      = reset & iOrD;
  assign mem_read    = reset & memRead;
  assign mem_write   = reset & memWrite;
  assign ir_write    = reset & irWrite;
  assign pc_write    = reset & pcWrite;
  assign pc_src      = reset & pcSrc;
  assign reg2loc     = reset & reg2locC;
  assign alu_src     = reset & aluSrc;
  assign alu_op      = reset ? aluOp : 2'b00;
  assign mem_to_reg  = reset & memToReg;
  assign reg_write   = reset & regWrite;
  assign state       = curState;
  assign instr_count = instrCount;
  assign illegal     = illegalQ;
  assign mem_error   = memErrQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: a table of whole-instruction outcomes driven by a
// memory responder, then directed and random instructions checked cycle by cycle
// against a per-instruction script model.
module tb_multicycle_control;
  localparam int T = 15;

  localparam logic [10:0] ADD  = 11'b10001011000;
  localparam logic [10:0] SUB  = 11'b11001011000;
  localparam logic [10:0] ANDI = 11'b10001010000;
  localparam logic [10:0] ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010;
  localparam logic [10:0] STUR = 11'b11111000000;
  localparam logic [10:0] CBZ  = 11'b10110100101;
  localparam logic [10:0] BOP  = 11'b00010100000;
  localparam logic [10:0] BAD  = 11'b11111111111;

  localparam int C_R = 0, C_LD = 1, C_ST = 2, C_CBZ = 3, C_B = 4, C_ILL = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] opcode;
  logic        alu_zero, mem_ready;
  logic        mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src;
  logic        reg2loc, alu_src, mem_to_reg, reg_write, illegal, mem_error;
  logic [1:0]  alu_op;
  logic [2:0]  state;
  logic [31:0] instr_count;

  multicycle_control #(.OPCODE_W(11), .CNT_W(32), .MEM_TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .reg2loc(reg2loc),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .state(state), .instr_count(instr_count), .illegal(illegal), .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  logic [12:0] actVec;
  assign actVec = {mem_req, i_or_d, mem_read, mem_write, ir_write, pc_write, pc_src,
                   reg2loc, alu_src, alu_op, mem_to_reg, reg_write};

  int          nTests = 0, nFail = 0;
  logic [31:0] expCnt;
  bit          expIll, expErr;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] op);
    casez (op)
      ADD, SUB, ANDI, ORR: return C_R;
      LDUR:                return C_LD;
      STUR:                return C_ST;
      11'b10110100???:     return C_CBZ;
      11'b000101?????:     return C_B;
      default:             return C_ILL;
    endcase
  endfunction

  // Expected control outputs for a state, straight from the per-state output table.
  function automatic logic [12:0] expVec(input logic [2:0] st, input bit rdy, input bit zero,
                                         input bit ld, input bit isB);
    logic req, iod, rd, wr, irw, pcw, pcs, r2l, asrc, m2r, rw;
    logic [1:0] aop;
    {req, iod, rd, wr, irw, pcw, pcs, r2l, asrc, m2r, rw} = '0;
    aop = 2'b00;
    case (st)
      3'd0: begin req = 1; rd = 1; irw = rdy; pcw = rdy; end
      3'd2: aop = 2'b10;
      3'd3: begin asrc = 1; r2l = 1; end
      3'd4: begin req = 1; iod = 1; rd = 1; end
      3'd5: begin req = 1; iod = 1; wr = 1; r2l = 1; end
      3'd6: begin rw = 1; m2r = ld; end
      3'd7: begin r2l = 1; aop = 2'b01; pcs = 1; pcw = isB | zero; end
      default: ;
    endcase
    return {req, iod, rd, wr, irw, pcw, pcs, r2l, asrc, aop, m2r, rw};
  endfunction

  // One clock cycle of the script model: drive, check, advance to the next negedge.
  task automatic step(input logic [2:0] st, input bit rdy, input logic [10:0] opDrv,
                      input bit zero, input bit ld, input bit isB);
    opcode = opDrv; alu_zero = zero; mem_ready = rdy;
    #1;
    check("state", state, st);
    check("outputs", actVec, expVec(st, rdy, zero, ld, isB));
    check("instr_count", instr_count, expCnt);
    check("illegal", illegal, expIll);
    check("mem_error", mem_error, expErr);
    expIll = 0; expErr = 0;
    @(negedge clk);
  endtask

  // A memory state that sees w not-ready cycles; w >= T aborts after T of them.
  task automatic memPhase(input logic [2:0] st, input int w, input logic [10:0] op,
                          input bit zero, input bit ld, output bit ok);
    int n;
    n = (w < T) ? w : T;
    for (int k = 0; k < n; k++) step(st, 0, (st == 3'd0) ? 11'($urandom) : op, zero, ld, 0);
    if (w >= T) begin
      expErr = 1; ok = 0;
    end else begin
      step(st, 1, (st == 3'd0) ? 11'($urandom) : op, zero, ld, 0);
      ok = 1;
    end
  endtask

  task automatic doInstr(input logic [10:0] op, input bit zero, input int fw, input int mw);
    int c; bit ld, isB, ok;
    c = classify(op); ld = (c == C_LD); isB = (c == C_B);
    memPhase(3'd0, fw, op, zero, 0, ok);
    if (!ok) return;
    step(3'd1, 1'($urandom), op, zero, 0, 0);
    case (c)
      C_R: begin
        step(3'd2, 1'($urandom), op, zero, 0, 0);
        step(3'd6, 1'($urandom), op, zero, 0, 0);
        expCnt++;
      end
      C_LD, C_ST: begin
        step(3'd3, 1'($urandom), op, zero, ld, 0);
        memPhase(ld ? 3'd4 : 3'd5, mw, op, zero, ld, ok);
        if (ok) begin
          if (ld) step(3'd6, 1'($urandom), op, zero, 1, 0);
          expCnt++;
        end
      end
      C_CBZ, C_B: begin
        step(3'd7, 1'($urandom), op, zero, 0, isB);
        expCnt++;
      end
      default: expIll = 1;
    endcase
  endtask

  // Runs one instruction with a responder that answers after fw/mw waits.
  // It reports the DUT's own cycle count, retire delta and end-of-instruction pulses.
  task automatic runDut(input logic [10:0] op, input bit zero, input int fw, input int mw,
                        output int cyc, output int ret, output bit ill, output bit err);
    logic [31:0] c0; int phaseW; logic [2:0] lastSt; bit done;
    c0 = instr_count; phaseW = 0; lastSt = state; cyc = 0; ret = 0; ill = 0; err = 0; done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      opcode   = (state == 3'd0) ? 11'($urandom) : op;
      alu_zero = zero;
      if (mem_req) mem_ready = (phaseW >= ((state == 3'd0) ? fw : mw));
      else         mem_ready = 1'($urandom);
      #1;
      if (mem_req && !mem_ready) phaseW++;
      @(negedge clk);
      cyc++;
      if (state != lastSt) phaseW = 0;
      if (state == 3'd0 && (lastSt != 3'd0 || mem_error)) begin
        done = 1; ill = illegal; err = mem_error; ret = int'(instr_count - c0);
      end
      lastSt = state;
    end
    if (!done) begin
      nTests++; nFail++;
      $display("FAIL runDut_bound: instruction %b did not return to FETCH within 60 cycles", op);
    end
  endtask

  typedef struct {
    logic [10:0] op;
    bit          zero;
    int          fw, mw;
    int          cyc, ret;
    bit          ill, err;
  } vecT;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vecT tbl[17];
    int cyc, ret; bit ill, err;
    tbl = '{
      '{ADD,  0, 0, 0,     4, 1, 0, 0},
      '{SUB,  1, 0, 0,     4, 1, 0, 0},
      '{ANDI, 0, 0, 0,     4, 1, 0, 0},
      '{ORR,  1, 0, 0,     4, 1, 0, 0},
      '{LDUR, 0, 0, 0,     5, 1, 0, 0},
      '{LDUR, 0, 0, 3,     8, 1, 0, 0},
      '{STUR, 0, 0, 0,     4, 1, 0, 0},
      '{STUR, 0, 0, T-1,  18, 1, 0, 0},
      '{LDUR, 0, 0, T-1,  19, 1, 0, 0},
      '{CBZ,  0, 0, 0,     3, 1, 0, 0},
      '{CBZ,  1, 0, 0,     3, 1, 0, 0},
      '{BOP,  0, 0, 0,     3, 1, 0, 0},
      '{BAD,  0, 0, 0,     2, 0, 1, 0},
      '{ADD,  0, 2, 0,     6, 1, 0, 0},
      '{ADD,  0, T, 0,     T, 0, 0, 1},
      '{LDUR, 0, 0, 20,  T+3, 0, 0, 1},
      '{STUR, 1, 0, T,   T+3, 0, 0, 1}
    };
    reset = 0; opcode = '0; alu_zero = 0; mem_ready = 0;
    expCnt = 0; expIll = 0; expErr = 0;

    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", actVec, 0);
    check("reset_state", state, 0);
    check("reset_count", instr_count, 0);
    check("reset_pulses", {illegal, mem_error}, 0);
    @(negedge clk);
    reset = 1;
    #1;
    check("release_mem_req", mem_req, 1);
    check("release_state", state, 0);

    for (int i = 0; i < 17; i++) begin
      runDut(tbl[i].op, tbl[i].zero, tbl[i].fw, tbl[i].mw, cyc, ret, ill, err);
      check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
      check($sformatf("tbl%0d_retire", i), ret, tbl[i].ret);
      check($sformatf("tbl%0d_illegal", i), ill, tbl[i].ill);
      check($sformatf("tbl%0d_mem_error", i), err, tbl[i].err);
    end

    // Asynchronous reset in the middle of a stalled store.
    mem_ready = 1; opcode = 11'($urandom);
    @(negedge clk); opcode = STUR; mem_ready = 0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("mw_state", state, 5);
    check("mw_mem_req", mem_req, 1);
    @(posedge clk);
    #3 reset = 0;
    #1;
    check("async_rst_outputs", actVec, 0);
    check("async_rst_state", state, 0);
    check("async_rst_count", instr_count, 0);
    @(posedge clk);
    #1;
    check("held_rst_mem_req", mem_req, 0);
    @(negedge clk);
    reset = 1;
    #1;
    check("post_rst_mem_req", mem_req, 1);
    check("post_rst_state", state, 0);
    check("post_rst_count", instr_count, 0);
    expCnt = 0;

    // Directed cycle-accurate cases.
    doInstr(ADD, 0, 0, 0);
    doInstr(LDUR, 1, 0, 3);
    doInstr(CBZ, 0, 0, 0);
    doInstr(CBZ, 1, 0, 0);
    doInstr(BOP, 0, 0, 0);
    doInstr(BAD, 0, 0, 0);
    doInstr(ADD, 0, T, 0);
    doInstr(STUR, 0, 0, T-1);
    doInstr(STUR, 1, 0, T);
    doInstr(LDUR, 0, 0, T+2);

    // Random instruction mix and memory latencies.
    for (int n = 0; n < 80; n++) begin
      logic [10:0] op;
      int k, fw, mw;
      k = $urandom_range(0, 8);
      case (k)
        0: op = ADD;
        1: op = SUB;
        2: op = ANDI;
        3: op = ORR;
        4: op = LDUR;
        5: op = STUR;
        6: op = {8'b10110100, 3'($urandom)};
        7: op = {6'b000101, 5'($urandom)};
        default: op = 11'($urandom);
      endcase
      fw = ($urandom_range(0, 9) == 0) ? $urandom_range(T-1, T+1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 5) == 0) ? $urandom_range(T-1, T+1) : $urandom_range(0, 3);
      doInstr(op, 1'($urandom), fw, mw);
    end
    step(3'd0, 0, 11'($urandom), 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
